// File: rtl/psum_accumulator.sv
// psum_accumulator: sums a programmable number of signed products onto a bias.
// It then applies optional ReLU, a round-half-up right shift and an int8 clamp.
// The result is presented on a valid/ready output port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; window parameters latched on start
// S_ACC   | accepting products (in_ready=1), one per cycle when valid
// S_ROUND | one cycle: relu, rounding shift, clamp into out_data
// S_OUT   | out_valid held with stable out_data until out_ready
module psum_accumulator #(
    parameter int PW    = 16,
    parameter int AW    = 32,
    parameter int CNT_W = 12,
    parameter int OW    = 8
) (
    input  logic                    clk,
    input  logic                    sclr,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_terms,
    input  logic signed [AW-1:0]    bias,
    input  logic [4:0]              shift,
    input  logic                    relu_en,
    input  logic                    in_valid,
    input  logic signed [PW-1:0]    in_p,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [OW-1:0]    out_data,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [AW:0]   ONE_EXT = {{AW{1'b0}}, 1'b1};
    localparam logic signed [AW:0]   OUT_MAX = (AW+1)'(2**(OW-1) - 1);
    localparam logic signed [AW:0]   OUT_MIN = (AW+1)'(-(2**(OW-1)));

    logic [1:0]              state;
    logic [1:0]              state_nx;

    logic signed [AW-1:0]    acc;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        nt_q;
    logic [4:0]              shift_q;
    logic                    relu_q;

    logic                    accept;
    logic                    last_term;
    logic signed [AW:0]      sum_ext;
    logic signed [AW-1:0]    acc_sat;
    logic signed [AW:0]      v_ext;
    logic signed [AW:0]      v_sh;
    logic signed [OW-1:0]    v_clamp;

    assign accept    = in_valid & in_ready;
    assign last_term = (cnt == (nt_q - CNT_ONE));

    // Saturating accumulate: one guard bit detects overflow instead of wrapping.
    always_comb begin
        sum_ext = {acc[AW-1], acc} + {{(AW+1-PW){in_p[PW-1]}}, in_p};
        acc_sat = sum_ext[AW-1:0];
        if (sum_ext[AW] != sum_ext[AW-1]) begin
            acc_sat = sum_ext[AW] ? ACC_MIN : ACC_MAX;
        end
    end

    // Requantisation: ReLU, round-half-up arithmetic shift, clamp to OW bits.
    // The extra bit keeps acc_max + 2^30 from overflowing during rounding.
    always_comb begin
        v_ext = {acc[AW-1], acc};
        if (relu_q && acc[AW-1]) begin
            v_ext = '0;
        end
        v_sh = v_ext;
        if (shift_q != 5'd0) begin
            v_sh = (v_ext + (ONE_EXT <<< (shift_q - 5'd1))) >>> shift_q;
        end
        if (v_sh > OUT_MAX) begin
            v_clamp = OUT_MAX[OW-1:0];
        end else if (v_sh < OUT_MIN) begin
            v_clamp = OUT_MIN[OW-1:0];
        end else begin
            v_clamp = v_sh[OW-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (num_terms == '0) ? S_ROUND : S_ACC;
                end
            end
            S_ACC: begin
                if (accept && last_term) begin
                    state_nx = S_ROUND;
                end
            end
            S_ROUND: state_nx = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready  = (state == S_ACC);
        out_valid = (state == S_OUT);
        busy      = (state != S_IDLE);
    end

    // Window datapath: parameter latch, accumulation, result and done pulse.
    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            acc      <= '0;
            cnt      <= '0;
            nt_q     <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            out_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == S_OUT) && out_ready;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nt_q    <= num_terms;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        acc     <= bias;
                        cnt     <= '0;
                    end
                end
                S_ACC: begin
                    if (accept) begin
                        acc <= acc_sat;
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_ROUND: out_data <= v_clamp;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: stimulus pushes expected activations,
// a monitor pops and compares on each output handshake.
module tb_psum_accumulator;

    logic               clk = 1'b0;
    logic               sclr = 1'b1;
    logic               start = 1'b0;
    logic [11:0]        num_terms = '0;
    logic signed [31:0] bias = '0;
    logic [4:0]         shift = '0;
    logic               relu_en = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] in_p = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic               out_ready = 1'b1;
    logic               busy;
    logic               done;

    int checks = 0;
    int passed = 0;
    int done_count = 0;
    int windows = 0;
    logic signed [7:0] exp_q[$];

    psum_accumulator dut (
        .clk(clk), .sclr(sclr), .start(start), .num_terms(num_terms),
        .bias(bias), .shift(shift), .relu_en(relu_en), .in_valid(in_valid),
        .in_p(in_p), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_window(input logic [11:0] nt, input logic signed [31:0] b,
                                input logic [4:0] sh, input logic rl);
        num_terms = nt; bias = b; shift = sh; relu_en = rl; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] p);
        in_valid = 1'b1; in_p = p;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check("wait_idle_timeout", 1, 0);
        tick();
    endtask

    // Monitor: compare every handshaken activation, then confirm done/busy.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                @(negedge clk);
                check("done_after_hs", done, 1);
                check("busy_after_hs", busy, 0);
            end
        end
    end

    // Count done pulses.
    always @(negedge clk) if (done) done_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] vpat;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        tick(); tick();
        sclr = 1'b0;
        tick();

        // 1: plain sum
        exp_q.push_back(8'sd25); windows++;
        start_window(12'd3, 0, 5'd0, 1'b0);
        check("t1_in_ready_acc", in_ready, 1);
        send(16'sd10); send(16'sd20); send(-16'sd5);
        wait_idle();

        // 2: relu on, then relu off with negative saturation
        exp_q.push_back(8'sd0); windows++;
        start_window(12'd2, -100, 5'd0, 1'b1);
        send(-16'sd300); send(-16'sd300);
        wait_idle();
        exp_q.push_back(-8'sd128); windows++;
        start_window(12'd2, -100, 5'd0, 1'b0);
        send(-16'sd300); send(-16'sd300);
        wait_idle();

        // 3: rounding shift, positive and negative halves
        exp_q.push_back(8'sd3); windows++;
        start_window(12'd1, 0, 5'd4, 1'b0);
        send(16'sd40);
        wait_idle();
        exp_q.push_back(-8'sd2); windows++;
        start_window(12'd1, 0, 5'd4, 1'b0);
        send(-16'sd40);
        wait_idle();

        // 4: in_valid gaps, only four accepts count
        exp_q.push_back(8'sd4); windows++;
        start_window(12'd4, 0, 5'd0, 1'b0);
        vpat = 8'b1011001;
        for (int i = 6; i >= 0; i--) begin
            if (vpat[i]) send(16'sd1);
            else tick();
        end
        wait_idle();
        check("t4_in_ready_idle", in_ready, 0);

        // zero-term window: bias only, (50+1)>>>1 = 25
        exp_q.push_back(8'sd25); windows++;
        start_window(12'd0, 50, 5'd1, 1'b0);
        check("t0_in_ready_round", in_ready, 0);
        wait_idle();

        // accumulator saturates at +max instead of wrapping; >>>31 rounds to 1
        exp_q.push_back(8'sd1); windows++;
        start_window(12'd1, 32'sh7FFF_FFF0, 5'd31, 1'b0);
        send(16'sh7FFF);
        wait_idle();

        // 5: backpressure, stability, ignored start, latency
        out_ready = 1'b0;
        exp_q.push_back(8'sd12); windows++;
        start_window(12'd2, 5, 5'd0, 1'b0);
        send(16'sd3); send(16'sd4);
        check("t5_valid_in_round", out_valid, 0);
        tick();
        check("t5_valid_latency", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; num_terms = 12'd1;
            tick();
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_data", out_data, 12);
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        tick();
        check("t5_no_restart", busy, 0);

        // 6: reset mid-window discards partial sum
        start_window(12'd5, 0, 5'd0, 1'b0);
        send(16'sd100); send(16'sd100);
        #2;
        sclr = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_in_ready", in_ready, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_out_data", out_data, 0);
        check("t6_rst_done", done, 0);
        tick();
        sclr = 1'b0;
        tick();
        exp_q.push_back(8'sd7); windows++;
        start_window(12'd1, 0, 5'd0, 1'b0);
        send(16'sd7);
        wait_idle();
        tick(); tick();

        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_count, windows);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
